// File: rtl/pwm_ramp.sv
// pwm_ramp
// ---------------------------------------------------------------------------
// Front end of the PWM generator. It turns a signed speed command into an
// unsigned duty word plus a direction bit. Duty changes by at most `step` per
// ramp tick. On a direction reversal, duty ramps down to zero, stays at zero
// for a dwell period, then dir flips and duty ramps up again.
//
// Parameters:
//   nbits         duty width (must match the PWM generator)
//   step          duty change per ramp tick, 1 .. 2**nbits-1
//   ramp_div      clk cycles per ramp tick, >= 1
//   reverse_dwell ramp ticks at zero duty before dir flips, >= 0
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         enable; low forces duty to 0 and parks the FSM in IDLE
//   target     signed two's-complement speed command, sampled every cycle
//   duty       registered unsigned duty word to the PWM generator
//   dir        registered direction, 0 = forward, 1 = reverse
//   at_target  duty and dir match the command
//   fsm_state  debug view of the FSM: 0 = IDLE, 1 = RUN, 2 = DWELL
// ---------------------------------------------------------------------------
module pwm_ramp #(
  parameter int nbits         = 10,
  parameter int step          = 8,
  parameter int ramp_div      = 4800,
  parameter int reverse_dwell = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [nbits:0]   target,
  output logic [nbits-1:0] duty,
  output logic             dir,
  output logic             at_target,
  output logic [1:0]       fsm_state
);

  // Refuse to build with a prescaler or step that could never make progress.
  if (ramp_div < 1 || step < 1) begin : g_param_check
    $fatal(1, "pwm_ramp: ramp_div and step must both be >= 1");
  end

  localparam int pw = (ramp_div > 1) ? $clog2(ramp_div) : 1;
  localparam int dw = (reverse_dwell > 0) ? $clog2(reverse_dwell + 1) : 1;

  localparam logic [pw-1:0]    presc_last = pw'(ramp_div - 1);
  localparam logic [dw-1:0]    dwell_load = dw'(reverse_dwell);
  localparam logic [nbits-1:0] step_n     = nbits'(step);
  localparam logic [nbits:0]   step_w     = (nbits + 1)'(step);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [nbits-1:0] duty_next;
  logic             dir_next;
  logic [dw-1:0]    dwell, dwell_next;
  logic [pw-1:0]    presc;
  logic             tick;

  // -------------------------------------------------------------------------
  // Command decode
  // -------------------------------------------------------------------------
  logic             t_dir;
  logic [nbits:0]   abs_w;
  logic [nbits-1:0] t_mag;
  logic             reversal;

  always_comb begin
    t_dir = target[nbits];
    abs_w = t_dir ? (~target + 1'b1) : target;
    // Only the most negative command has its top bit set after negation.
    t_mag = abs_w[nbits] ? {nbits{1'b1}} : abs_w[nbits-1:0];
    reversal = (t_mag != '0) && (t_dir != dir);
  end

  // -------------------------------------------------------------------------
  // Ramp prescaler: tick is high for one cycle every ramp_div enabled cycles.
  // -------------------------------------------------------------------------
  assign tick = en && (presc == presc_last);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Slew arithmetic, done one bit wider than duty so duty+step cannot wrap.
  // -------------------------------------------------------------------------
  logic [nbits:0]   duty_w, mag_w, up_sum;
  logic [nbits-1:0] up_val, down_val, rev_val;

  always_comb begin
    duty_w   = {1'b0, duty};
    mag_w    = {1'b0, t_mag};
    up_sum   = duty_w + step_w;
    up_val   = (up_sum > mag_w) ? t_mag : up_sum[nbits-1:0];
    // Step down only if that does not undershoot the commanded magnitude.
    down_val = (duty_w >= (mag_w + step_w)) ? (duty - step_n) : t_mag;
    // Ramp toward zero ahead of a reversal.
    rev_val  = (duty_w > step_w) ? (duty - step_n) : '0;
  end

  // -------------------------------------------------------------------------
  // FSM next state and datapath updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    duty_next  = duty;
    dir_next   = dir;
    dwell_next = dwell;

    if (!en) begin
      state_next = IDLE;
      duty_next  = '0;
      dwell_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_next = RUN;
        end

        RUN: begin
          if (tick) begin
            if (reversal) begin
              if (duty != '0) begin
                duty_next = rev_val;
              end else begin
                state_next = DWELL;
                dwell_next = dwell_load;
              end
            end else if (duty < t_mag) begin
              duty_next = up_val;
            end else if (duty > t_mag) begin
              duty_next = down_val;
            end
          end
        end

        DWELL: begin
          if (tick) begin
            if (!reversal) begin
              // Command came back to the current direction (or to zero).
              state_next = RUN;
            end else if (dwell == '0) begin
              // Duty is zero throughout the dwell, so dir may flip here.
              dir_next   = t_dir;
              state_next = RUN;
            end else begin
              dwell_next = dwell - 1'b1;
            end
          end
        end

        default: begin
          state_next = IDLE;
          duty_next  = '0;
          dwell_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty  <= '0;
      dir   <= 1'b0;
      dwell <= '0;
    end else begin
      state <= state_next;
      duty  <= duty_next;
      dir   <= dir_next;
      dwell <= dwell_next;
    end
  end

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  assign at_target = (state == RUN) && en && (duty == t_mag) &&
                     ((t_dir == dir) || (t_mag == '0));
  assign fsm_state = state;

endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp
// ---------------------------------------------------------------------------
// Bench for pwm_ramp with nbits=8, step=16, ramp_div=4, reverse_dwell=2.
// Expected {at_target, dir, duty} per ramp tick is pushed to exp_q before the
// ticks run; each tick is popped and compared four cycles later. Between ticks
// duty/dir must hold their last expected value.
// ---------------------------------------------------------------------------
module tb_pwm_ramp;

  localparam int NB = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NB:0]   target;
  logic [NB-1:0] duty;
  logic          dir;
  logic          at_target;
  logic [1:0]    fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] exp_q[$];
  logic [9:0] last_exp;

  pwm_ramp #(
    .nbits(NB), .step(16), .ramp_div(4), .reverse_dwell(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .target(target),
    .duty(duty), .dir(dir), .at_target(at_target), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] pk(input int a, input int d, input int v);
    return {a[0], d[0], v[7:0]};
  endfunction

  // Driver / scoreboard tasks
  task automatic push(input int a, input int d, input int v);
    exp_q.push_back(pk(a, d, v));
  endtask

  task automatic run_ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_val($sformatf("%s[%0d]_hold", tag, k), 32'({dir, duty}), 32'(last_exp[8:0]));
      end
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s[%0d]: scoreboard empty", tag, k);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check_val($sformatf("%s[%0d]", tag, k), 32'({at_target, dir, duty}), 32'(e));
        last_exp = e;
      end
    end
  endtask

  task automatic check_out(input string tag, input int a, input int d, input int v, input logic [1:0] st);
    check_val({tag, "_out"}, 32'({at_target, dir, duty}), 32'(pk(a, d, v)));
    check_val({tag, "_state"}, 32'(fsm_state), 32'(st));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; target = 9'd100; last_exp = '0;

    // Reset
    repeat (2) @(negedge clk);
    check_out("reset", 0, 0, 0, S_IDLE);
    rst = 1'b0;

    // Ramp up to +100
    for (int v = 16; v <= 96; v += 16) push(0, 0, v);
    push(1, 0, 100); push(1, 0, 100); push(1, 0, 100);
    run_ticks("ramp_up", 9);

    // Reversal to -50
    target = 9'(-50);
    push(0, 0, 84); push(0, 0, 68); push(0, 0, 52); push(0, 0, 36);
    push(0, 0, 20); push(0, 0, 4);  push(0, 0, 0);
    push(0, 0, 0);                       // enter dwell
    run_ticks("rev_down", 8);
    check_out("rev_dwell_entry", 0, 0, 0, S_DWELL);
    push(0, 0, 0); push(0, 0, 0);
    run_ticks("rev_dwell", 2);
    check_out("rev_dwell_last", 0, 0, 0, S_DWELL);
    push(0, 1, 0);                       // dir flips, duty still zero
    run_ticks("rev_flip", 1);
    check_out("rev_flip", 0, 1, 0, S_RUN);
    push(0, 1, 16); push(0, 1, 32); push(0, 1, 48); push(1, 1, 50); push(1, 1, 50);
    run_ticks("rev_up", 5);

    // Dwell abort: reverse to +30, then return to reverse during dwell
    target = 9'd30;
    push(0, 1, 34); push(0, 1, 18); push(0, 1, 2); push(0, 1, 0);
    push(0, 1, 0); push(0, 1, 0);        // dwell entry, first dwell tick
    run_ticks("abort_down", 6);
    check_out("abort_in_dwell", 0, 1, 0, S_DWELL);
    target = 9'(-40);
    push(0, 1, 0);
    run_ticks("abort_exit", 1);
    check_out("abort_exit", 0, 1, 0, S_RUN);
    push(0, 1, 16); push(0, 1, 32); push(1, 1, 40); push(1, 1, 40);
    run_ticks("abort_up", 4);

    // Saturation: -256 from rest; reset also clears dir
    target = 9'h100;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_out("sat_reset", 0, 0, 0, S_IDLE);
    rst = 1'b0; last_exp = '0;
    push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 1, 0);
    for (int v = 16; v <= 240; v += 16) push(0, 1, v);
    push(1, 1, 255); push(1, 1, 255);
    run_ticks("saturate", 21);

    // Ramp down to -64, then drop enable
    target = 9'(-64);
    for (int v = 239; v >= 79; v -= 16) push(0, 1, v);
    push(1, 1, 64);
    run_ticks("down64", 12);
    en = 1'b0;
    @(negedge clk);
    check_out("en_drop", 0, 1, 0, S_IDLE);
    en = 1'b1; last_exp = pk(0, 1, 0);
    push(0, 1, 16); push(0, 1, 32); push(0, 1, 48); push(1, 1, 64);
    run_ticks("reenable", 4);

    // Pending reversal across an enable drop mid-dwell
    target = 9'd64;
    push(0, 1, 48); push(0, 1, 32); push(0, 1, 16); push(0, 1, 0);
    push(0, 1, 0); push(0, 1, 0);
    run_ticks("pend_down", 6);
    check_out("pend_dwell", 0, 1, 0, S_DWELL);
    en = 1'b0;
    @(negedge clk);
    check_out("pend_en_drop", 0, 1, 0, S_IDLE);
    en = 1'b1;
    push(0, 1, 0); push(0, 1, 0); push(0, 1, 0); push(0, 0, 0);
    push(0, 0, 16); push(0, 0, 32); push(0, 0, 48); push(1, 0, 64);
    run_ticks("pend_full_dwell", 8);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
